loop_ctrl: RTL and testbench
============================

Name: loop_ctrl

Overview:
- Two-level loop sequencer that sits directly upstream of the controller's index counters and datapath.
- Accepts one loop instruction (inner/outer bounds) over a valid/ready handshake.
- Emits one step per inner iteration with the current inner/outer indices over a valid/ready stream, then signals completion.
- Replaces hand-wired inc/max_count control with a handshaked, backpressure-aware stage.

Parameters:
- BIT_WIDTH, 5, width of each loop bound and index; both are inclusive maxima (max=N gives N+1 iterations).

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns block to IDLE
- inst_valid  input  1  instruction offered
- inst_ready  output  1  block can accept an instruction
- inst_inner_max  input  BIT_WIDTH  inclusive inner bound
- inst_outer_max  input  BIT_WIDTH  inclusive outer bound
- step_valid  output  1  step presented downstream
- step_ready  input  1  downstream accepts step
- inner_idx  output  BIT_WIDTH  current inner index
- outer_idx  output  BIT_WIDTH  current outer index
- step_last_inner  output  1  inner_idx==inner bound (qualified by step_valid)
- step_last  output  1  final step of the instruction (both indices at bound)
- done  output  1  single-cycle pulse after the final step handshake
- busy  output  1  state != IDLE

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, both indices=0, latched bounds=0.
- Reset outputs: inst_ready=1, step_valid=0, step_last_inner=0, step_last=0, done=0, busy=0.
- States: IDLE, RUN.
  - IDLE: inst_ready=1, step_valid=0.
  - RUN: inst_ready=0, step_valid=1.
- IDLE->RUN on inst_valid&&inst_ready (cycle T):
  - latch both bounds;
  - indices=0;
  - step_valid=1 from T+1 (one-cycle latency).
- Step handshake (fire = step_valid&&step_ready):
  - fire, inner!=inner_bound: inner+1.
  - fire, inner==inner_bound, outer!=outer_bound: inner=0, outer+1.
  - fire on step_last: indices=0, state->IDLE, done=1 next cycle; inst_ready=1 in that same cycle.
- No fire: indices, step_valid and all step outputs hold; values stay stable under backpressure.
- Back-to-back instructions: a new instruction may be accepted in the cycle done is high. No instruction is accepted while in RUN.
- Bounds of 0/0: exactly one step, with step_last=1 on it.
- Bounds at all-ones (31/31 default): 1024 steps, no wrap or overflow of the index arithmetic. Comparisons are equality only; no +1 on the bounds themselves.
- Total steps per instruction = (inner_max+1)*(outer_max+1).
- Instruction inputs are sampled only on accept; later changes are ignored.
- flush (synchronous, highest priority after rstn), from any state:
  - state=IDLE, indices=0, no done pulse;
  - a step_valid&&step_ready in the same cycle as flush is not counted.
- flush with inst_valid in IDLE: flush wins, nothing accepted that cycle.
- rstn asserted mid-RUN: immediate return to reset values, no done.
- done, step_last and step_last_inner are registered or derived from registered state only; no combinational path from step_ready to step_valid.

Decomposition:
- Shared controller package holds:
  - typedef enum for the state (LOOP_IDLE, LOOP_RUN);
  - typedef idx_t = logic [BIT_WIDTH-1:0];
  - localparam for the default width.
- One sub-module is natural: loop_idx, a wrap-at-bound index register with inc, synchronous clear and an at-bound flag. It is instantiated twice (inner, outer).
- The existing counter is not reused because a synchronous clear is required for flush.

Test Plan:
- Reset then inst inner=2, outer=1 accepted at T, step_ready held 1 -> step_valid from T+1.
  - (inner,outer) sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1);
  - step_last only on (2,1);
  - done pulse at T+7;
  - inst_ready=1 at T+7.
- Same instruction with step_ready toggling 1,0,0,1,... -> indices hold during every step_ready=0 cycle; still exactly 6 fires in the same order.
- Inst 0/0 -> one step with step_last=1, done next cycle. Inst 31/31 -> 1024 fires; final indices (31,31); returns to (0,0) in IDLE.
- inst_valid held high during RUN with different bounds -> ignored. A second instruction in the done cycle -> accepted, its first step at the following cycle.
- flush asserted on the 3rd step of 2/1, with step_ready=1 -> IDLE next cycle, indices (0,0), no done pulse; the next instruction starts at (0,0).
- rstn dropped asynchronously mid-RUN -> outputs take reset values before the next clock edge; no done after rstn release.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// rtl/loop_ctrl_pkg.sv - shared types and defaults for the two-level loop sequencer
package loop_ctrl_pkg;

  // Default width of loop bounds and indices; bounds are inclusive maxima.
  localparam int LOOP_BIT_WIDTH = 5;

  typedef logic [LOOP_BIT_WIDTH-1:0] idx_t;

  typedef enum logic {
    LOOP_IDLE = 1'b0,
    LOOP_RUN  = 1'b1
  } loop_state_e;

endpackage

// File: rtl/loop_ctrl_if.sv
// rtl/loop_ctrl_if.sv - instruction and step handshake bundle for loop_ctrl
interface loop_ctrl_if
  import loop_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = LOOP_BIT_WIDTH
) ();

  // Instruction channel: one pair of inclusive loop bounds per transfer.
  logic                 inst_valid;
  logic                 inst_ready;
  logic [BIT_WIDTH-1:0] inst_inner_max;
  logic [BIT_WIDTH-1:0] inst_outer_max;

  // Step channel: one beat per inner iteration.
  logic                 step_valid;
  logic                 step_ready;
  logic [BIT_WIDTH-1:0] inner_idx;
  logic [BIT_WIDTH-1:0] outer_idx;
  logic                 step_last_inner;
  logic                 step_last;

  // Side that issues instructions and consumes steps.
  modport master (
    output inst_valid, inst_inner_max, inst_outer_max, step_ready,
    input  inst_ready, step_valid, inner_idx, outer_idx, step_last_inner, step_last
  );

  // Sequencer side.
  modport slave (
    input  inst_valid, inst_inner_max, inst_outer_max, step_ready,
    output inst_ready, step_valid, inner_idx, outer_idx, step_last_inner, step_last
  );

endinterface

// File: rtl/loop_idx.sv
// rtl/loop_idx.sv - index register that wraps to zero at an inclusive bound
module loop_idx
  import loop_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = LOOP_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [BIT_WIDTH-1:0] max_val,
  output logic [BIT_WIDTH-1:0] idx,
  output logic                 at_max
);

  // Equality only, so a bound of all-ones never needs a wider compare.
  assign at_max = (idx == max_val);

  // Clear beats increment; increment at the bound wraps instead of overflowing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= at_max ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/loop_ctrl.sv
// rtl/loop_ctrl.sv - two-level loop sequencer with handshaked instruction and step streams
module loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = LOOP_BIT_WIDTH
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       flush,
  loop_ctrl_if.slave lp,
  output logic       done,
  output logic       busy
);

  loop_state_e          state_q;
  loop_state_e          state_d;
  logic [BIT_WIDTH-1:0] inner_bound_q;
  logic [BIT_WIDTH-1:0] outer_bound_q;
  logic [BIT_WIDTH-1:0] inner_idx;
  logic [BIT_WIDTH-1:0] outer_idx;
  logic                 inner_at_max;
  logic                 outer_at_max;
  logic                 idx_clr;
  logic                 inner_inc;
  logic                 outer_inc;
  logic                 load;
  logic                 done_d;
  logic                 done_q;
  logic                 step_fire;

  assign step_fire = lp.step_valid && lp.step_ready;

  // Next state, handshake outputs and index controls; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    idx_clr       = 1'b0;
    inner_inc     = 1'b0;
    outer_inc     = 1'b0;
    load          = 1'b0;
    done_d        = 1'b0;
    lp.inst_ready = 1'b0;
    lp.step_valid = 1'b0;
    case (state_q)
      LOOP_IDLE: begin
        // Not ready during flush so a flushed offer is never seen as accepted.
        lp.inst_ready = !flush;
        if (lp.inst_valid && !flush) begin
          load    = 1'b1;
          idx_clr = 1'b1;
          state_d = LOOP_RUN;
        end
      end
      LOOP_RUN: begin
        lp.step_valid = 1'b1;
        if (step_fire) begin
          inner_inc = 1'b1;
          outer_inc = inner_at_max;
          if (inner_at_max && outer_at_max) begin
            idx_clr = 1'b1;
            state_d = LOOP_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = LOOP_IDLE;
    endcase
    if (flush) begin
      state_d   = LOOP_IDLE;
      idx_clr   = 1'b1;
      inner_inc = 1'b0;
      outer_inc = 1'b0;
      load      = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State register and the registered completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOOP_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Bounds are captured only on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inner_bound_q <= '0;
      outer_bound_q <= '0;
    end else if (load) begin
      inner_bound_q <= lp.inst_inner_max;
      outer_bound_q <= lp.inst_outer_max;
    end
  end

  loop_idx #(.BIT_WIDTH(BIT_WIDTH)) u_inner (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (idx_clr),
    .inc     (inner_inc),
    .max_val (inner_bound_q),
    .idx     (inner_idx),
    .at_max  (inner_at_max)
  );

  loop_idx #(.BIT_WIDTH(BIT_WIDTH)) u_outer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (idx_clr),
    .inc     (outer_inc),
    .max_val (outer_bound_q),
    .idx     (outer_idx),
    .at_max  (outer_at_max)
  );

  assign lp.inner_idx       = inner_idx;
  assign lp.outer_idx       = outer_idx;
  assign lp.step_last_inner = lp.step_valid && inner_at_max;
  assign lp.step_last       = lp.step_valid && inner_at_max && outer_at_max;
  assign done               = done_q;
  assign busy               = (state_q != LOOP_IDLE);

endmodule

// File: tb/tb_loop_ctrl.sv
// tb/tb_loop_ctrl.sv - scoreboard bench for loop_ctrl
module tb_loop_ctrl;
  import loop_ctrl_pkg::*;

  localparam int W     = LOOP_BIT_WIDTH;
  localparam int LIMIT = 3000;

  typedef struct {
    int inner;
    int outer;
    bit last_inner;
    bit last;
  } step_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic done;
  logic busy;

  loop_ctrl_if #(.BIT_WIDTH(W)) lif ();

  loop_ctrl #(.BIT_WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .lp    (lif),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  step_t exp_q[$];
  int    vectors       = 0;
  int    errors        = 0;
  int    fires         = 0;
  bit    exp_done_next = 1'b0;
  int    ready_mode    = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every (inner, outer) pair in loop order.
  task automatic push_model(input int im, input int om);
    for (int o = 0; o <= om; o++) begin
      for (int i = 0; i <= im; i++) begin
        step_t s;
        s.inner      = i;
        s.outer      = o;
        s.last_inner = (i == im);
        s.last       = (i == im) && (o == om);
        exp_q.push_back(s);
      end
    end
  endtask

  // Downstream ready: always, the 1,0,0 pattern, or random.
  initial begin
    int pat;
    pat = 0;
    lif.step_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: lif.step_ready = 1'b1;
        1: begin
          lif.step_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
        default: lif.step_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every presented step with the scoreboard head, pop on fire.
  always @(negedge clk) begin
    if (rstn) begin
      if (exp_done_next) begin
        chk("done_pulse", int'(done), 1);
        chk("ready_in_done", int'(lif.inst_ready), 1);
      end else begin
        chk("done_low", int'(done), 0);
      end
      exp_done_next = 1'b0;
      if (lif.step_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          chk("inner_idx", int'(lif.inner_idx), exp_q[0].inner);
          chk("outer_idx", int'(lif.outer_idx), exp_q[0].outer);
          chk("step_last_inner", int'(lif.step_last_inner), int'(exp_q[0].last_inner));
          chk("step_last", int'(lif.step_last), int'(exp_q[0].last));
          if (lif.step_ready && !flush) begin
            fires++;
            if (exp_q[0].last) exp_done_next = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        if (!flush) chk("missing_step", exp_q.size(), 0);
        chk("idle_inner", int'(lif.inner_idx), 0);
        chk("idle_outer", int'(lif.outer_idx), 0);
        chk("idle_last", int'(lif.step_last), 0);
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic send_inst(input int im, input int om, input bit b2b);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    lif.inst_valid     = 1'b1;
    lif.inst_inner_max = W'(im);
    lif.inst_outer_max = W'(om);
    while (!acc && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (lif.inst_ready && !flush && rstn) acc = 1'b1;
    end
    chk("inst_accept_timeout", int'(acc), 1);
    if (!acc) begin
      lif.inst_valid = 1'b0;
      return;
    end
    if (b2b) chk("b2b_in_done_cycle", int'(done), 1);
    @(posedge clk);
    push_model(im, om);
    #1;
    lif.inst_valid     = 1'b0;
    lif.inst_inner_max = W'($urandom);
    lif.inst_outer_max = W'($urandom);
    @(negedge clk);
    chk("first_step_valid", int'(lif.step_valid), 1);
    chk("busy_run", int'(busy), 1);
    chk("ready_in_run", int'(lif.inst_ready), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < LIMIT), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int start, input int count);
    int n;
    n = 0;
    while ((fires - start) < count && n < LIMIT) begin
      @(posedge clk);
      n++;
    end
    chk("fire_wait_timeout", int'(n < LIMIT), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  start;
    bit  pending;
    int  im;
    int  om;
    lif.inst_valid     = 1'b0;
    lif.inst_inner_max = '0;
    lif.inst_outer_max = '0;
    flush = 1'b0;
    rstn  = 1'b0;
    #3;
    chk("rst_inst_ready", int'(lif.inst_ready), 1);
    chk("rst_step_valid", int'(lif.step_valid), 0);
    chk("rst_last_inner", int'(lif.step_last_inner), 0);
    chk("rst_last", int'(lif.step_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_inner", int'(lif.inner_idx), 0);
    chk("rst_outer", int'(lif.outer_idx), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 2/1 with ready held, then with 1,0,0 backpressure.
    ready_mode = 0;
    send_inst(2, 1, 1'b0);
    wait_idle();
    ready_mode = 1;
    send_inst(2, 1, 1'b0);
    wait_idle();

    // Single-step and full-range instructions.
    ready_mode = 0;
    send_inst(0, 0, 1'b0);
    wait_idle();
    start = fires;
    send_inst(31, 31, 1'b0);
    wait_idle();
    chk("full_range_fires", fires - start, 1024);

    // Offer held through RUN with other bounds is taken only in the done cycle.
    ready_mode = 2;
    send_inst(1, 1, 1'b0);
    lif.inst_valid     = 1'b1;
    lif.inst_inner_max = W'(3);
    lif.inst_outer_max = W'(2);
    send_inst(3, 2, 1'b1);
    wait_idle();

    // Flush on the third step of 2/1 with ready high.
    ready_mode = 0;
    start = fires;
    send_inst(2, 1, 1'b0);
    wait_fires(start, 2);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", int'(busy), 0);
    chk("flush_step_valid", int'(lif.step_valid), 0);
    chk("flush_fires", fires - start, 2);
    @(posedge clk);
    #1;
    lif.inst_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    lif.inst_valid = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", int'(busy), 0);
    @(posedge clk);
    #1;
    send_inst(1, 0, 1'b0);
    wait_idle();

    // Asynchronous reset mid-RUN.
    start = fires;
    send_inst(3, 3, 1'b0);
    wait_fires(start, 5);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_step_valid", int'(lif.step_valid), 0);
    chk("arst_inst_ready", int'(lif.inst_ready), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_inner", int'(lif.inner_idx), 0);
    chk("arst_outer", int'(lif.outer_idx), 0);
    chk("arst_last", int'(lif.step_last), 0);
    exp_q.delete();
    exp_done_next = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_inst(1, 1, 1'b0);
    wait_idle();

    // Random instructions, ready patterns and occasional back-to-back offers.
    pending = 1'b0;
    for (int k = 0; k < 24; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      im = int'($urandom_range(0, 6));
      om = int'($urandom_range(0, 4));
      send_inst(im, om, pending);
      pending = ($urandom_range(0, 2) == 0);
      if (!pending) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    if (pending) wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
